// File: rtl/comparator_serial_nbit.sv
// Digit-serial magnitude comparator: one 2-bit digit per clock, MSD first, with cascade inputs.
// Latency WIDTH/2 cycles (or first-differing-digit position with EARLY_EXIT); start ignored while busy.
module comparator_serial_nbit #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             lin,
  input  logic             gin,
  input  logic             ein,
  output logic             busy,
  output logic             done,
  output logic             lout,
  output logic             gout,
  output logic             eout
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("comparator_serial_nbit: WIDTH must be even and >= 2");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       cas_q, cas_d;
  logic             diff_q, diff_d, gt_q, gt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             lout_q, lout_d, gout_q, gout_d, eout_q, eout_d;

  logic [1:0] a_dig, b_dig;
  logic       dig_ne, dig_gt, found, found_gt, last;

  always_comb begin
    a_dig = 2'b00;
    b_dig = 2'b00;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == CW'(i)) begin
        a_dig = a_q[2*i +: 2];
        b_dig = b_q[2*i +: 2];
      end
    end
  end

  assign dig_ne   = (a_dig != b_dig);
  assign dig_gt   = (a_dig > b_dig);
  assign found    = diff_q | dig_ne;
  assign found_gt = diff_q ? gt_q : dig_gt;
  assign last     = (idx_q == '0) || ((EARLY_EXIT != 0) && dig_ne);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cas_d   = cas_q;
    diff_d  = diff_q;
    gt_d    = gt_q;
    done_d  = 1'b0;
    lout_d  = lout_q;
    gout_d  = gout_q;
    eout_d  = eout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = a ^ {signed_mode, {(WIDTH-1){1'b0}}};
          b_d     = b ^ {signed_mode, {(WIDTH-1){1'b0}}};
          cas_d   = {lin, gin, ein};
          idx_d   = CW'(NDIG - 1);
          diff_d  = 1'b0;
          gt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      default: begin
        diff_d = found;
        gt_d   = found_gt;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (found) begin
            lout_d = ~found_gt;
            gout_d = found_gt;
            eout_d = 1'b0;
          end else begin
            lout_d = cas_q[2];
            gout_d = ~cas_q[2] & cas_q[1];
            // ein or an all-zero cascade both mean equal.
            eout_d = ~cas_q[2] & ~cas_q[1] & (cas_q[0] | (cas_q[2:1] == 2'b00));
          end
        end else begin
          idx_d = idx_q - CW'(1);
        end
      end
    endcase
    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= '0;
      diff_q  <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lout_q  <= 1'b0;
      gout_q  <= 1'b0;
      eout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cas_q   <= cas_d;
      diff_q  <= diff_d;
      gt_q    <= gt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lout_q  <= lout_d;
      gout_q  <= gout_d;
      eout_q  <= eout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lout = lout_q;
  assign gout = gout_q;
  assign eout = eout_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Directed bench for comparator_serial_nbit: WIDTH=8 without and with early exit, plus WIDTH=2.
module tb_comparator_serial_nbit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       sm8 = 1'b0;
  logic [2:0] cas8 = '0;
  logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       sm2 = 1'b0;
  logic [2:0] cas2 = '0;

  logic busy0, done0, l0, g0, e0;
  logic busy1, done1, l1, g1, e1;
  logic busy2, done2, l2, g2, e2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comparator_serial_nbit #(.WIDTH(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a8), .b(b8), .signed_mode(sm8),
    .lin(cas8[2]), .gin(cas8[1]), .ein(cas8[0]),
    .busy(busy0), .done(done0), .lout(l0), .gout(g0), .eout(e0));

  comparator_serial_nbit #(.WIDTH(8), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a8), .b(b8), .signed_mode(sm8),
    .lin(cas8[2]), .gin(cas8[1]), .ein(cas8[0]),
    .busy(busy1), .done(done1), .lout(l1), .gout(g1), .eout(e1));

  comparator_serial_nbit #(.WIDTH(2), .EARLY_EXIT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .signed_mode(sm2),
    .lin(cas2[2]), .gin(cas2[1]), .ein(cas2[0]),
    .busy(busy2), .done(done2), .lout(l2), .gout(g2), .eout(e2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic dn(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic bz(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic logic [2:0] lge(input int sel);
    return (sel == 0) ? {l0, g0, e0} : (sel == 1) ? {l1, g1, e1} : {l2, g2, e2};
  endfunction

  function automatic logic [4:0] all_out(input int sel);
    return {bz(sel), dn(sel), lge(sel)};
  endfunction

  // Issue one compare, scramble the inputs after capture, and wait for done.
  task automatic launch(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic sm, input logic [2:0] cas, output int lat, output int bc);
    if (sel == 2) begin
      a2 = av[1:0]; b2 = bv[1:0]; sm2 = sm; cas2 = cas; start2 = 1'b1;
    end else begin
      a8 = av; b8 = bv; sm8 = sm; cas8 = cas;
      if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    end
    tick();
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a8 = ~av; b8 = ~bv; sm8 = ~sm; cas8 = ~cas;
    a2 = ~av[1:0]; b2 = ~bv[1:0]; sm2 = ~sm; cas2 = ~cas;
    lat = 0;
    bc  = 0;
    while (!dn(sel) && lat < 20) begin
      if (bz(sel)) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input int sel, input logic [7:0] av, input logic [7:0] bv,
                     input logic sm, input logic [2:0] cas, input int exp_lat, input logic [2:0] exp_lge);
    int lat, bc;
    launch(sel, av, bv, sm, cas, lat, bc);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_lge"}, {29'd0, lge(sel)}, {29'd0, exp_lge});
    chk({tag, "_busy_at_done"}, {31'd0, bz(sel)}, 32'd0);
    tick();
    chk({tag, "_done_pulse"}, {31'd0, dn(sel)}, 32'd0);
  endtask

  initial begin
    int lat, bc;
    #12;
    chk("rst0", {27'd0, all_out(0)}, 32'd0);
    chk("rst1", {27'd0, all_out(1)}, 32'd0);
    chk("rst2", {27'd0, all_out(2)}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic unsigned compare, busy width and latency.
    launch(0, 8'h5A, 8'h5B, 1'b0, 3'b000, lat, bc);
    chk("u5a5b_lat", lat, 4);
    chk("u5a5b_busy_cycles", bc, 4);
    chk("u5a5b_lge", {29'd0, lge(0)}, 32'b100);
    tick();
    chk("u5a5b_done_pulse", {31'd0, done0}, 32'd0);

    run("s80_01", 0, 8'h80, 8'h01, 1'b1, 3'b000, 4, 3'b100);
    run("u80_01", 0, 8'h80, 8'h01, 1'b0, 3'b000, 4, 3'b010);
    run("sff_fe", 0, 8'hFF, 8'hFE, 1'b1, 3'b000, 4, 3'b010);

    run("eq_c010", 0, 8'h3C, 8'h3C, 1'b0, 3'b010, 4, 3'b010);
    run("eq_c100", 0, 8'h3C, 8'h3C, 1'b0, 3'b100, 4, 3'b100);
    run("eq_c000", 0, 8'h3C, 8'h3C, 1'b0, 3'b000, 4, 3'b001);
    run("eq_c110", 0, 8'h3C, 8'h3C, 1'b0, 3'b110, 4, 3'b100);
    run("eq_c001", 0, 8'h3C, 8'h3C, 1'b0, 3'b001, 4, 3'b001);

    // Sticky first difference: later digits favour B but A wins on the MSD.
    run("nee_c0_40", 0, 8'hC0, 8'h7F, 1'b0, 3'b100, 4, 3'b010);
    run("ee_c0_40", 1, 8'hC0, 8'h40, 1'b0, 3'b000, 1, 3'b010);
    run("ee_12_13", 1, 8'h12, 8'h13, 1'b0, 3'b000, 4, 3'b100);
    run("ee_eq", 1, 8'h3C, 8'h3C, 1'b0, 3'b010, 4, 3'b010);

    // start pulsed mid-scan must be ignored.
    a8 = 8'h10; b8 = 8'h20; sm8 = 1'b0; cas8 = 3'b000; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    a8 = 8'hFF; b8 = 8'h00; cas8 = 3'b010; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    lat = 2;
    while (!done0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("ignore_lat", lat, 4);
    chk("ignore_lge", {29'd0, l0, g0, e0}, 32'b100);
    tick();
    chk("ignore_idle", {30'd0, busy0, done0}, 32'd0);

    // start held high through done: back-to-back with a one-cycle busy gap.
    a8 = 8'h5A; b8 = 8'h5B; start0 = 1'b1;
    tick();
    a8 = 8'hF0; b8 = 8'h0F; cas8 = 3'b000;
    lat = 0;
    while (!done0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("b2b_first_lat", lat, 4);
    chk("b2b_first_lge", {29'd0, l0, g0, e0}, 32'b100);
    chk("b2b_gap_busy", {31'd0, busy0}, 32'd0);
    tick();
    start0 = 1'b0;
    chk("b2b_recapture", {30'd0, busy0, done0}, 32'b10);
    lat = 0;
    while (!done0 && lat < 20) begin
      tick();
      lat++;
    end
    chk("b2b_second_lat", lat, 4);
    chk("b2b_second_lge", {29'd0, l0, g0, e0}, 32'b010);
    tick();

    // Reset in the middle of a scan.
    a8 = 8'h00; b8 = 8'hFF; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst0", {27'd0, all_out(0)}, 32'd0);
    chk("midrst1", {27'd0, all_out(1)}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("postrst_idle", {27'd0, all_out(0)}, 32'd0);
    run("post_00_ff", 0, 8'h00, 8'hFF, 1'b0, 3'b000, 4, 3'b100);

    run("w2_10_01", 2, 8'h02, 8'h01, 1'b0, 3'b000, 1, 3'b010);
    run("w2_s10_01", 2, 8'h02, 8'h01, 1'b1, 3'b000, 1, 3'b100);
    run("w2_eq_c100", 2, 8'h03, 8'h03, 1'b0, 3'b100, 1, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
